// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - shared register-file constants and writeback types
package reg_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;
    localparam int AGE_W      = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;

    localparam reg_addr_t REG_ZERO = '0;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wr_req_t;

    // Register 0 is hardwired zero; writes to it are accepted but dropped.
    function automatic logic writes_reg(input reg_addr_t addr);
        return addr != REG_ZERO;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_scoreboard.sv
// rtl/reg_write_arbiter_scoreboard.sv - pending-write busy vector with set/clear and two queries
module reg_scoreboard
    import reg_write_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      set_i,
    input  reg_addr_t set_addr_i,
    input  logic      clr_i,
    input  reg_addr_t clr_addr_i,
    input  reg_addr_t q_addr_s_i,
    input  reg_addr_t q_addr_t_i,
    output logic      q_busy_s_o,
    output logic      q_busy_t_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Set is applied after clear so a re-issue in the completing cycle stays pending.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign q_busy_s_o = busy_q[q_addr_s_i];
    assign q_busy_t_o = busy_q[q_addr_t_i];

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - two-requester register writeback arbiter with B aging and scoreboard
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int AGE_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [4:0]       a_addr,
    input  logic [31:0]      a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [4:0]       b_addr,
    input  logic [31:0]      b_data,
    input  logic             sb_set,
    input  logic [4:0]       sb_set_addr,
    input  logic [4:0]       q_addr_s,
    input  logic [4:0]       q_addr_t,
    output logic             q_busy_s,
    output logic             q_busy_t,
    output logic             reg_write,
    output logic [4:0]       write_addr,
    output logic [31:0]      write_data,
    output logic [1:0]       b_age
);

    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

    logic [AGE_W-1:0] b_age_q, b_age_d;
    logic             reg_write_q, reg_write_d;
    wr_req_t          wr_q, wr_d;
    logic             b_aged;
    logic             a_xfer;
    logic             b_xfer;

    // Ready depends only on valids and age so requesters never see an address-driven loop.
    assign b_aged  = (b_age_q == AGE_MAX);
    assign a_ready = ~b_aged;
    assign b_ready = ~a_valid | b_aged;
    assign a_xfer  = a_valid & a_ready;
    assign b_xfer  = b_valid & b_ready;

    always_comb begin
        b_age_d = b_age_q;
        if (!b_valid || b_xfer) begin
            b_age_d = '0;
        end else if (!b_aged) begin
            b_age_d = b_age_q + 1'b1;
        end
    end

    always_comb begin
        wr_d        = wr_q;
        reg_write_d = 1'b0;
        if (a_xfer) begin
            wr_d        = '{addr: a_addr, data: a_data};
            reg_write_d = writes_reg(a_addr);
        end else if (b_xfer) begin
            wr_d        = '{addr: b_addr, data: b_data};
            reg_write_d = writes_reg(b_addr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_age_q     <= '0;
            reg_write_q <= 1'b0;
            wr_q        <= '0;
        end else begin
            b_age_q     <= b_age_d;
            reg_write_q <= reg_write_d;
            wr_q        <= wr_d;
        end
    end

    reg_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_i      (sb_set),
        .set_addr_i (sb_set_addr),
        .clr_i      (b_xfer),
        .clr_addr_i (b_addr),
        .q_addr_s_i (q_addr_s),
        .q_addr_t_i (q_addr_t),
        .q_busy_s_o (q_busy_s),
        .q_busy_t_o (q_busy_t)
    );

    assign reg_write  = reg_write_q;
    assign write_addr = wr_q.addr;
    assign write_data = wr_q.data;
    assign b_age      = b_age_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed vector bench for reg_write_arbiter
module tb_reg_write_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid, b_valid, sb_set;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr, sb_set_addr, q_addr_s, q_addr_t;
    logic [31:0] a_data, b_data;
    logic        q_busy_s, q_busy_t;
    logic        reg_write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [1:0]  b_age;

    int n_cmp;
    int n_bad;

    reg_write_arbiter #(.AGE_LIMIT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .sb_set     (sb_set),
        .sb_set_addr(sb_set_addr),
        .q_addr_s   (q_addr_s),
        .q_addr_t   (q_addr_t),
        .q_busy_s   (q_busy_s),
        .q_busy_t   (q_busy_t),
        .reg_write  (reg_write),
        .write_addr (write_addr),
        .write_data (write_data),
        .b_age      (b_age)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        ss;
        logic [4:0]  ssa;
        logic [4:0]  qs;
        logic [4:0]  qt;
        logic        ar;
        logic        br;
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  age;
        logic        bs;
        logic        bt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        a_valid     = v.av;
        a_addr      = v.aa;
        a_data      = v.ad;
        b_valid     = v.bv;
        b_addr      = v.ba;
        b_data      = v.bd;
        sb_set      = v.ss;
        sb_set_addr = v.ssa;
        q_addr_s    = v.qs;
        q_addr_t    = v.qt;
    endtask

    task automatic idle();
        a_valid = 1'b0; a_addr = 5'd0; a_data = 32'd0;
        b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
        sb_set  = 1'b0; sb_set_addr = 5'd0;
        q_addr_s = 5'd0; q_addr_t = 5'd0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle();
        rst = 1'b1;

        //          av    aa     ad            bv    ba     bd            ss    ssa    qs     qt     ar    br    rw    wa     wd            age   bs    bt
        vecs[0]  = '{1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 5'd5, 32'h0000_1234, 2'd0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd8, 32'h0000_BEEF, 1'b1, 5'd9, 5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 5'd8, 32'h0000_BEEF, 2'd0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 5'd8, 5'd9, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0033, 2'd1, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 5'd3, 32'h0000_0044, 1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 5'd8, 5'd9, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0044, 2'd2, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 5'd3, 32'h0000_0055, 1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 5'd8, 5'd9, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0055, 2'd3, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 5'd3, 32'h0000_0066, 1'b1, 5'd9, 32'h0000_0099, 1'b1, 5'd9, 5'd8, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_0099, 2'd0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 2'd0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 5'd4, 32'h0000_0040, 1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0040, 2'd1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 5'd4, 32'h0000_0041, 1'b0, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0041, 2'd0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h0000_0077, 1'b0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0000_0077, 2'd0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h0000_00AB, 1'b0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_00AB, 2'd0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
        chk("rst_write_addr", {27'd0, write_addr}, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_b_age", {30'd0, b_age}, 32'd0);
        chk("rst_a_ready", {31'd0, a_ready}, 32'd1);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd1);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_a_ready", i), {31'd0, a_ready}, {31'd0, vecs[i].ar});
            chk($sformatf("v%0d_b_ready", i), {31'd0, b_ready}, {31'd0, vecs[i].br});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_reg_write", i), {31'd0, reg_write}, {31'd0, vecs[i].rw});
            chk($sformatf("v%0d_write_addr", i), {27'd0, write_addr}, {27'd0, vecs[i].wa});
            chk($sformatf("v%0d_write_data", i), write_data, vecs[i].wd);
            chk($sformatf("v%0d_b_age", i), {30'd0, b_age}, {30'd0, vecs[i].age});
            chk($sformatf("v%0d_q_busy_s", i), {31'd0, q_busy_s}, {31'd0, vecs[i].bs});
            chk($sformatf("v%0d_q_busy_t", i), {31'd0, q_busy_t}, {31'd0, vecs[i].bt});
        end

        // Build up busy bits 3 and 7, a pending write and a non-zero age, then reset mid-cycle.
        @(negedge clk);
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h0000_0003;
        b_valid = 1'b1; b_addr = 5'd12; b_data = 32'h0000_0C0C;
        sb_set = 1'b1; sb_set_addr = 5'd3;
        q_addr_s = 5'd3; q_addr_t = 5'd7;
        @(negedge clk);
        a_addr = 5'd7; a_data = 32'h0000_0007;
        sb_set_addr = 5'd7;
        @(posedge clk);
        #1;
        chk("pre_rst_reg_write", {31'd0, reg_write}, 32'd1);
        chk("pre_rst_busy3", {31'd0, q_busy_s}, 32'd1);
        chk("pre_rst_busy7", {31'd0, q_busy_t}, 32'd1);
        chk("pre_rst_b_age", {30'd0, b_age}, 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_reg_write", {31'd0, reg_write}, 32'd0);
        chk("async_rst_write_addr", {27'd0, write_addr}, 32'd0);
        chk("async_rst_write_data", write_data, 32'd0);
        chk("async_rst_busy3", {31'd0, q_busy_s}, 32'd0);
        chk("async_rst_busy7", {31'd0, q_busy_t}, 32'd0);
        chk("async_rst_b_age", {30'd0, b_age}, 32'd0);

        @(negedge clk);
        idle();
        q_addr_s = 5'd3; q_addr_t = 5'd7;
        rst = 1'b0;
        #1;
        chk("post_rst_a_ready", {31'd0, a_ready}, 32'd1);
        chk("post_rst_b_ready", {31'd0, b_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("post_rst_reg_write", {31'd0, reg_write}, 32'd0);
        chk("post_rst_busy3", {31'd0, q_busy_s}, 32'd0);

        // First edge after deassertion must be usable.
        @(negedge clk);
        a_valid = 1'b1; a_addr = 5'd21; a_data = 32'hCAFE_0021;
        @(posedge clk);
        #1;
        chk("first_xfer_reg_write", {31'd0, reg_write}, 32'd1);
        chk("first_xfer_write_addr", {27'd0, write_addr}, 32'd21);
        chk("first_xfer_write_data", write_data, 32'hCAFE_0021);

        @(negedge clk);
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter AGE_LIMIT, default 3: consecutive blocked cycles of requester B before B is granted over A.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: a_valid input 1, a_ready output 1, a_addr input 5, a_data input 32 -- requester A (single-cycle ALU/load writeback).
REQ-005 SHALL have ports: b_valid input 1, b_ready output 1, b_addr input 5, b_data input 32 -- requester B (multi-cycle mult/div writeback).
REQ-006 SHALL have ports: sb_set input 1, sb_set_addr input 5 -- mark a register pending on multi-cycle issue.
REQ-007 SHALL have ports: q_addr_s input 5, q_addr_t input 5, q_busy_s output 1, q_busy_t output 1 -- scoreboard queries for source/target.
REQ-008 SHALL have ports: reg_write output 1, write_addr output 5, write_data output 32 -- register file write port.
REQ-009 SHALL have port: b_age output 2 -- current B blocked-cycle count, for debug.

Function
REQ-010 SHALL grant at most one requester per cycle; a transfer occurs when valid and ready are both high at a rising edge.
REQ-011 SHALL, by default, give A priority: a_ready=1 always unless B is aged; b_ready=1 only when a_valid=0 or B is aged.
REQ-012 SHALL increment b_age on each edge where b_valid=1 and b_ready=0, saturating at AGE_LIMIT; clear to 0 on any B transfer or when b_valid=0.
REQ-013 SHALL treat B as aged when b_age==AGE_LIMIT; then b_ready=1 and a_ready=0 for that cycle.
REQ-014 SHALL register the granted request: reg_write, write_addr, write_data update at the transfer edge (1-cycle latency); with no transfer, reg_write=0 next cycle and write_addr/write_data hold.
REQ-015 SHALL accept transfers to address 0 but drive reg_write=0 for them.
REQ-016 SHALL keep a 32-bit busy vector; bit n set at an edge where sb_set=1 and sb_set_addr=n (n!=0); bit n cleared at an edge where a B transfer to n occurs.
REQ-017 SHALL let set win when set and clear target the same address in the same cycle.
REQ-018 SHALL keep busy bit 0 always 0.
REQ-019 SHALL drive q_busy_s/q_busy_t combinationally from the registered busy vector (no same-cycle bypass of sb_set or clear).
REQ-020 SHALL leave A transfers unaffected by the scoreboard (no clear on A writes).
REQ-021 SHALL compute a_ready/b_ready combinationally from a_valid, b_valid, b_age only (no dependency on data/address).

Reset
REQ-022 SHALL, while rst=1, force reg_write=0, write_addr=0, write_data=0, busy vector=0, b_age=0, independent of clk.
REQ-023 SHALL drop any request in flight at reset assertion; no write is issued in the cycle following deassertion unless a new transfer occurs.
REQ-024 SHALL drive a_ready=1, b_ready as per REQ-011 once rst deasserts (first edge usable).

Structure
REQ-025 SHALL take REG_ADDR_W=5, DATA_W=32, NUM_REGS=32 from the shared MIPS package, together with the register-file constants.
REQ-026 SHALL contain one natural sub-module, reg_scoreboard (busy vector, set/clear, two query ports); arbitration and output register stay in the top.

Verification
REQ-027 SHALL cover: a_valid=1 addr=5 data=0x1234 alone -> next cycle reg_write=1, write_addr=5, write_data=0x1234.
REQ-028 SHALL cover: a_valid and b_valid held 1 every cycle, AGE_LIMIT=3 -> A granted 3 cycles, B granted on 4th (a_ready=0 that cycle), b_age back to 0.
REQ-029 SHALL cover: sb_set addr=8, then q_addr_s=8 -> q_busy_s=1 next cycle; B transfer addr=8 -> q_busy_s=0 the cycle after.
REQ-030 SHALL cover: same cycle sb_set addr=9 and B transfer addr=9 with bit 9 already set -> bit 9 remains 1.
REQ-031 SHALL cover: A transfer addr=0 data=0xFFFFFFFF -> reg_write=0; sb_set addr=0 -> q_busy for 0 stays 0.
REQ-032 SHALL cover: rst asserted mid-sequence between edges with busy bits 3,7 set and reg_write=1 -> immediately reg_write=0, all busy=0, b_age=0.
